// File: rtl/active_list_commit_if.sv
// Dispatch, writeback and commit bundle between the rename/WriteBack stages and
// the in-order active list.
interface active_list_commit_if #(
    parameter int AL_LOG       = 6,
    parameter int WB_FLAGS     = 6,
    parameter int COMMIT_WIDTH = 4
);
    logic                                 disp_valid;
    logic [2:0]                           disp_count;
    logic                                 disp_ready;
    logic [AL_LOG-1:0]                    disp_index;
    logic [3:0]                           wb_valid;
    logic [3:0][AL_LOG+WB_FLAGS-1:0]      wb_packet;
    logic                                 flush;
    logic [COMMIT_WIDTH-1:0]              commit_valid;
    logic [AL_LOG-1:0]                    head_index;
    logic                                 exception;
    logic [AL_LOG-1:0]                    exception_index;
    logic [AL_LOG:0]                      count;

    modport master (
        output disp_valid, disp_count, wb_valid, wb_packet, flush,
        input  disp_ready, disp_index, commit_valid, head_index,
               exception, exception_index, count
    );

    modport slave (
        input  disp_valid, disp_count, wb_valid, wb_packet, flush,
        output disp_ready, disp_index, commit_valid, head_index,
               exception, exception_index, count
    );
endinterface

// File: rtl/active_list_commit.sv
// Circular active list: allocates at dispatch, marks entries done from WriteBack,
// retires done entries in program order and requests recovery on a head exception.
module active_list_commit #(
    parameter int SIZE_AL        = 64,
    parameter int AL_LOG         = 6,
    parameter int WB_FLAGS       = 6,
    parameter int DISPATCH_WIDTH = 4,
    parameter int COMMIT_WIDTH   = 4
) (
    input logic                 clk,
    input logic                 reset,
    active_list_commit_if.slave bus
);
    localparam int CW_LOG = $clog2(COMMIT_WIDTH + 1);

    typedef logic [AL_LOG-1:0] idx_t;
    typedef logic [AL_LOG:0]   cnt_t;

    idx_t               head_q, tail_q;
    cnt_t               count_q;
    logic [SIZE_AL-1:0] done_q, exc_q, done_d, exc_d;
    logic [SIZE_AL-1:0] wb_hit, wb_exc;
    logic [CW_LOG-1:0]  commit_n;
    logic               disp_fire, recover, scan_stop, unused_flags;
    idx_t               scan_idx, wb_idx;

    assign bus.disp_ready      = count_q <= cnt_t'(SIZE_AL - DISPATCH_WIDTH);
    assign disp_fire           = bus.disp_valid && bus.disp_ready;
    assign bus.disp_index      = tail_q;
    assign bus.head_index      = head_q;
    assign bus.count           = count_q;
    assign bus.exception       = (count_q != '0) && done_q[head_q] && exc_q[head_q];
    assign bus.exception_index = head_q;
    assign recover             = bus.flush || bus.exception;

    // Retire scan stops at the first entry that is not done, is excepting, or is past the tail.
    always_comb begin
        // NOTE: every variable driven here gets a default first so no latch is inferred.
        commit_n         = '0;
        scan_stop        = 1'b0;
        scan_idx         = head_q;
        bus.commit_valid = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            scan_idx = head_q + idx_t'(i);
            if (scan_stop || cnt_t'(i) >= count_q || !done_q[scan_idx] || exc_q[scan_idx])
                scan_stop = 1'b1;
            else
                commit_n = commit_n + 1'b1;
        end
        for (int i = 0; i < COMMIT_WIDTH; i++)
            bus.commit_valid[i] = CW_LOG'(i) < commit_n;
    end

    always_comb begin
        done_d       = done_q;
        exc_d        = exc_q;
        wb_hit       = '0;
        wb_exc       = '0;
        wb_idx       = '0;
        unused_flags = 1'b0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (disp_fire && 3'(i) < bus.disp_count) begin
                done_d[tail_q + idx_t'(i)] = 1'b0;
                exc_d[tail_q + idx_t'(i)]  = 1'b0;
            end
        end
        // Same-index writes on two ports merge, so collect hits before applying them.
        for (int p = 0; p < 4; p++) begin
            wb_idx       = bus.wb_packet[p][AL_LOG+WB_FLAGS-1 -: AL_LOG];
            unused_flags = unused_flags ^ (^bus.wb_packet[p][WB_FLAGS-1:1]);
            if (bus.wb_valid[p] && cnt_t'(idx_t'(wb_idx - head_q)) < count_q) begin
                wb_hit[wb_idx] = 1'b1;
                wb_exc[wb_idx] = wb_exc[wb_idx] | bus.wb_packet[p][0];
            end
        end
        done_d = done_d | wb_hit;
        exc_d  = (exc_d & ~wb_hit) | wb_exc;
    end

    always_ff @(posedge clk) begin
        // NOTE: the status bits are flops rather than a RAM, so they are cleared on reset and flush.
        if (reset || recover) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge state.
            head_q  <= head_q + idx_t'(commit_n);
            tail_q  <= tail_q + (disp_fire ? idx_t'(bus.disp_count) : idx_t'(0));
            count_q <= count_q + (disp_fire ? cnt_t'(bus.disp_count) : cnt_t'(0)) - cnt_t'(commit_n);
            done_q  <= done_d;
            exc_q   <= exc_d;
        end
    end
endmodule

// File: tb/tb_active_list_commit.sv
// Directed bench for active_list_commit: a vector table for the single-cycle
// behaviour plus hand sequences for fill/back-pressure and pointer wrap.
module tb_active_list_commit;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    active_list_commit_if bus ();
    active_list_commit dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic            dv;
        logic [2:0]      dc;
        logic [3:0]      wv;
        logic [3:0][11:0] pkt;
        logic            fl;
        logic            e_ready;
        logic [5:0]      e_dindex;
        logic [3:0]      e_cv;
        logic [5:0]      e_head;
        logic            e_exc;
        logic [5:0]      e_eidx;
        logic [6:0]      e_count;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] pk(input logic [5:0] idx, input logic exc);
        return {idx, 5'b0, exc};
    endfunction

    function automatic void add(input logic dv, input logic [2:0] dc, input logic [3:0] wv,
                                input logic [11:0] p0, input logic [11:0] p1,
                                input logic [11:0] p2, input logic [11:0] p3, input logic fl,
                                input logic er, input logic [5:0] ed, input logic [3:0] ecv,
                                input logic [5:0] eh, input logic ee, input logic [5:0] ei,
                                input logic [6:0] ec);
        vec_t v;
        v.dv = dv; v.dc = dc; v.wv = wv; v.pkt = {p3, p2, p1, p0}; v.fl = fl;
        v.e_ready = er; v.e_dindex = ed; v.e_cv = ecv; v.e_head = eh;
        v.e_exc = ee; v.e_eidx = ei; v.e_count = ec;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [2:0] dc, input logic [3:0] wv,
                         input logic [3:0][11:0] pkt, input logic fl);
        bus.disp_valid = dv;
        bus.disp_count = dc;
        bus.wb_valid   = wv;
        bus.wb_packet  = pkt;
        bus.flush      = fl;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 4'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [5:0] tb_tail;

    // Allocate n entries, write them all back, then let them retire.
    task automatic batch(input int n);
        logic [3:0][11:0] p;
        logic [3:0]       wv;
        @(negedge clk);
        drive(1'b1, 3'(n), 4'b0, '0, 1'b0);
        p  = '0;
        wv = '0;
        for (int i = 0; i < n; i++) begin
            p[i]  = pk(tb_tail + 6'(i), 1'b0);
            wv[i] = 1'b1;
        end
        @(negedge clk);
        drive(1'b0, 3'd0, wv, p, 1'b0);
        @(negedge clk);
        idle();
        tb_tail = tb_tail + 6'(n);
    endtask

    initial begin
        logic [3:0][11:0] p;

        //   dv dc  wv       p0         p1         p2          p3    fl | rdy idx cv    head exc eidx count
        add(1, 4, 4'b0000, 0,         0,         0,          0,     0,  1,  0, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 4'b1111, pk(2,0),   pk(0,0),   pk(1,0),    pk(3,0), 0, 1, 4, 4'b0000, 0, 0, 0, 4);
        add(0, 0, 4'b0000, 0,         0,         0,          0,     0,  1,  4, 4'b1111, 0, 0, 0, 4);
        add(0, 0, 4'b0000, 0,         0,         0,          0,     0,  1,  4, 4'b0000, 4, 0, 0, 0);
        add(1, 4, 4'b0000, 0,         0,         0,          0,     0,  1,  4, 4'b0000, 4, 0, 0, 0);
        add(0, 0, 4'b0111, pk(4,0),   pk(5,0),   pk(7,0),    0,     0,  1,  8, 4'b0000, 4, 0, 0, 4);
        add(0, 0, 4'b0000, 0,         0,         0,          0,     0,  1,  8, 4'b0011, 4, 0, 0, 4);
        add(0, 0, 4'b0001, pk(6,0),   0,         0,          0,     0,  1,  8, 4'b0000, 6, 0, 0, 2);
        add(0, 0, 4'b0000, 0,         0,         0,          0,     0,  1,  8, 4'b0011, 6, 0, 0, 2);
        add(0, 0, 4'b0000, 0,         0,         0,          0,     0,  1,  8, 4'b0000, 8, 0, 0, 0);
        add(1, 4, 4'b0000, 0,         0,         0,          0,     0,  1,  8, 4'b0000, 8, 0, 0, 0);
        add(0, 0, 4'b0011, pk(8,0),   pk(9,1),   0,          0,     0,  1, 12, 4'b0000, 8, 0, 0, 4);
        add(0, 0, 4'b0000, 0,         0,         0,          0,     0,  1, 12, 4'b0001, 8, 0, 0, 4);
        add(0, 0, 4'b0000, 0,         0,         0,          0,     0,  1, 12, 4'b0000, 9, 1, 9, 3);
        add(0, 0, 4'b0000, 0,         0,         0,          0,     0,  1,  0, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 4'b0100, 0,         0,         pk(10,1),   0,     0,  1,  0, 4'b0000, 0, 0, 0, 0);
        add(1, 4, 4'b0000, 0,         0,         0,          0,     0,  1,  0, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 4'b0111, pk(0,1),   pk(0,0),   pk(10,0),   0,     0,  1,  4, 4'b0000, 0, 0, 0, 4);
        add(0, 0, 4'b0000, 0,         0,         0,          0,     0,  1,  4, 4'b0000, 0, 1, 0, 4);
        add(1, 4, 4'b0000, 0,         0,         0,          0,     1,  1,  0, 4'b0000, 0, 0, 0, 0);
        add(1, 0, 4'b0000, 0,         0,         0,          0,     0,  1,  0, 4'b0000, 0, 0, 0, 0);
        add(1, 2, 4'b0000, 0,         0,         0,          0,     0,  1,  0, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 4'b0001, pk(1,0),   0,         0,          0,     1,  1,  2, 4'b0000, 0, 0, 0, 2);
        add(0, 0, 4'b0000, 0,         0,         0,          0,     0,  1,  0, 4'b0000, 0, 0, 0, 0);

        do_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].dv, vecs[i].dc, vecs[i].wv, vecs[i].pkt, vecs[i].fl);
            #1;
            check($sformatf("v%0d ready", i), 32'(bus.disp_ready), 32'(vecs[i].e_ready));
            check($sformatf("v%0d dindex", i), 32'(bus.disp_index), 32'(vecs[i].e_dindex));
            check($sformatf("v%0d commit", i), 32'(bus.commit_valid), 32'(vecs[i].e_cv));
            check($sformatf("v%0d head", i), 32'(bus.head_index), 32'(vecs[i].e_head));
            check($sformatf("v%0d exc", i), 32'(bus.exception), 32'(vecs[i].e_exc));
            if (vecs[i].e_exc)
                check($sformatf("v%0d exc_idx", i), 32'(bus.exception_index), 32'(vecs[i].e_eidx));
            check($sformatf("v%0d count", i), 32'(bus.count), 32'(vecs[i].e_count));
            @(negedge clk);
        end

        // Fill to the back-pressure threshold.
        do_reset();
        for (int b = 0; b < 15; b++) begin
            drive(1'b1, 3'd4, 4'b0, '0, 1'b0);
            @(negedge clk);
        end
        drive(1'b1, 3'd1, 4'b0, '0, 1'b0);
        #1;
        check("fill60 ready", 32'(bus.disp_ready), 32'd1);
        check("fill60 count", 32'(bus.count), 32'd60);
        @(negedge clk);
        drive(1'b1, 3'd4, 4'b0, '0, 1'b0);
        #1;
        check("fill61 ready", 32'(bus.disp_ready), 32'd0);
        check("fill61 count", 32'(bus.count), 32'd61);
        @(negedge clk);
        drive(1'b0, 3'd0, 4'b1111, {pk(3,0), pk(2,0), pk(1,0), pk(0,0)}, 1'b0);
        #1;
        check("blocked count", 32'(bus.count), 32'd61);
        check("blocked tail", 32'(bus.disp_index), 32'd61);
        @(negedge clk);
        idle();
        #1;
        check("full commit", 32'(bus.commit_valid), 32'hf);
        @(negedge clk);
        drive(1'b0, 3'd0, 4'b0011, {12'h0, 12'h0, pk(5,0), pk(4,0)}, 1'b0);
        #1;
        check("drain ready", 32'(bus.disp_ready), 32'd1);
        check("drain count", 32'(bus.count), 32'd57);
        check("drain head", 32'(bus.head_index), 32'd4);
        @(negedge clk);
        drive(1'b1, 3'd3, 4'b0, '0, 1'b0);
        #1;
        check("mixed commit", 32'(bus.commit_valid), 32'h3);
        @(negedge clk);
        idle();
        #1;
        check("mixed count", 32'(bus.count), 32'd58);
        check("tail wrap", 32'(bus.disp_index), 32'd0);
        check("mixed head", 32'(bus.head_index), 32'd6);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset count", 32'(bus.count), 32'd0);
        check("midreset head", 32'(bus.head_index), 32'd0);
        check("midreset commit", 32'(bus.commit_valid), 32'd0);

        // Walk the head round to 62, then commit across the wrap.
        do_reset();
        tb_tail = '0;
        for (int b = 0; b < 15; b++) batch(4);
        batch(2);
        @(negedge clk);
        #1;
        check("pre-wrap head", 32'(bus.head_index), 32'd62);
        check("pre-wrap count", 32'(bus.count), 32'd0);
        check("pre-wrap tail", 32'(bus.disp_index), 32'd62);
        drive(1'b1, 3'd4, 4'b0, '0, 1'b0);
        @(negedge clk);
        p = {pk(1,0), pk(0,0), pk(63,0), pk(62,0)};
        drive(1'b0, 3'd0, 4'b1111, p, 1'b0);
        @(negedge clk);
        idle();
        #1;
        check("wrap commit", 32'(bus.commit_valid), 32'hf);
        check("wrap head", 32'(bus.head_index), 32'd62);
        check("wrap count", 32'(bus.count), 32'd4);
        @(negedge clk);
        #1;
        check("post-wrap head", 32'(bus.head_index), 32'd2);
        check("post-wrap count", 32'(bus.count), 32'd0);
        check("post-wrap tail", 32'(bus.disp_index), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/active_list_commit.md
Name: active_list_commit

Overview:
- In-order completion and retirement tracker directly downstream of WriteBack.
- Allocates one entry per dispatched instruction in a circular active list and consumes the WriteBack ctrlFU packets, formatted as {alIndex, flags}, to mark entries done.
- Retires up to COMMIT_WIDTH done entries per cycle in program order.
- Raises a one-cycle exception recovery request when the oldest entry completed with an exception.

Parameters:
SIZE_AL, 64, active list entries (power of two)
AL_LOG, 6, log2(SIZE_AL)
WB_FLAGS, 6, writeback flag width; flag[0]=exception, other bits ignored
DISPATCH_WIDTH, 4, max allocations per cycle
COMMIT_WIDTH, 4, max retirements per cycle

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dispValid_i  in  1  dispatch request
dispCount_i  in  3  entries requested, 0..DISPATCH_WIDTH
dispReady_o  out  1  at least DISPATCH_WIDTH free entries
dispIndex_o  out  AL_LOG  tail pointer = index of first allocated entry
wbValid_i  in  4  per-port writeback valid (writebkValid0..3)
wbPacket0_i..wbPacket3_i  in  AL_LOG+WB_FLAGS each  {alIndex, flags} (ctrlFU0..3)
flush_i  in  1  external pipeline flush
commitValid_o  out  COMMIT_WIDTH  thermometer code, bit k = entry head+k retires this cycle
headIndex_o  out  AL_LOG  head pointer
exception_o  out  1  head entry done with exception
exceptionIndex_o  out  AL_LOG  = head when exception_o
count_o  out  AL_LOG+1  occupancy

Behaviour:

State
- Per entry: done bit and exc bit.
- Registers: head, tail (AL_LOG bits, wrap mod SIZE_AL), count (AL_LOG+1 bits).

Reset and flush
- Reset: all state 0. Resulting outputs: dispReady_o=1, commitValid_o=0, exception_o=0, count_o=0, headIndex_o=0, dispIndex_o=0.

Dispatch
- dispReady_o = (count <= SIZE_AL-DISPATCH_WIDTH), combinational.
- Accepted when dispValid_i && dispReady_o. On the edge, entries tail..tail+dispCount_i-1 get done=0, exc=0, and tail += dispCount_i.
- Not accepted when dispReady_o=0: no state change. Upstream holds the request.
- dispCount_i=0 is a no-op.

Writeback
- Port p is in-window when wbValid_i[p] and ((alIndex-head) mod SIZE_AL) < count. Out-of-window writes are ignored.
- In-window write on the edge: done<=1, exc<=flags[0].
- Two ports naming the same index in one cycle: done and exc are OR-ed.
- Latency: a writeback at edge N is first visible to commit in the cycle after edge N.

Commit (combinational from current state)
- k = number of leading entries head, head+1, … (k ≤ min(COMMIT_WIDTH, count)) with done=1 and exc=0.
- commitValid_o[i] = (i<k).
- On the edge: head += k, count += accepted dispCount - k.
- Dispatch and commit in the same cycle both apply.

Exception
- exception_o = (count>0) && done[head] && exc[head]. Then k=0 and exceptionIndex_o=head.
- An exc entry behind head stops the scan. Older entries commit first; the exception is raised once that entry reaches head.
- On the edge after exception_o=1: full flush, the same as flush_i.

Flush
- flush_i or exception: head=tail=count=0 and all done/exc bits cleared on the edge.
- Flush has priority over dispatch, writeback and commit in the same cycle.

Boundaries
- Wrap-around at SIZE_AL-1 → 0 applies to head, tail and the commit scan.
- count==SIZE_AL cannot occur: dispReady_o blocks at SIZE_AL-DISPATCH_WIDTH+1 occupancy.
- Empty list (count=0): commitValid_o=0, exception_o=0.
- Reset mid-operation: state cleared on that edge; nothing commits in that cycle.

Test Plan:
1. Dispatch count 4 at reset, writeback idx 2,0,1,3 on ports 0..3 in one cycle → next cycle commitValid_o=4'b1111, headIndex_o=0; following cycle head=4, count=0.
2. Dispatch 4, writeback only idx 0,1,3 → commitValid_o=4'b0011; writeback idx 2 later → commitValid_o=4'b0011 (entries 2,3); count 0 afterwards.
3. Dispatch 4, writeback idx 0 flags=0, idx 1 flags[0]=1 → commitValid_o=4'b0001; next cycle exception_o=1, exceptionIndex_o=1; next cycle count_o=0, head=tail=0.
4. Fill to count 60 → dispReady_o=1; dispatch 4 → count 64-4+... blocked: at count 61 dispReady_o=0 and dispatch ignored; commit 4 → dispReady_o=1.
5. Start with head=62, dispatch 4 → entries 62,63,0,1; writeback all → commitValid_o=4'b1111, head wraps to 2.
6. Writeback idx 10 with count=0 → ignored, no commit; flush_i with concurrent dispatch 4 → count_o=0 next cycle, dispIndex_o=0.
